dec_queue_stage: RTL and testbench

Registered RV32I(+M) decode stage with an instruction queue, sitting between fetch and EX. Fetch pushes {pc, inst} into a DEPTH-entry FIFO over a valid/ready handshake. The head entry is decoded combinationally and loaded into an output register (the ID/EX register) under a downstream valid/ready handshake. Adds load-use interlock, pipeline flush, illegal-opcode detection and optional M-extension decode.

---
 rtl/dec_queue_stage.sv | 238 +++++++++++++++++++++++
 tb/tb_dec_queue_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_queue_stage.sv
// dec_queue_stage: RV32I(+M) decode stage with an instruction queue in front.
//
// Fetch pushes {pc, inst} into a DEPTH-entry FIFO over a valid/ready handshake.
// The FIFO head is decoded combinationally. The decoded result is loaded into
// the ID/EX output register when the downstream side can accept it. The stage
// holds the head for one cycle on a load-use dependency on the registered
// load. A flush discards everything queued and registered.
//
// Ports:
//   i_clk, i_rst            clock; synchronous active-high reset
//   i_f_valid/o_f_ready     fetch handshake (o_f_ready = count < DEPTH)
//   i_f_inst, i_f_pc        fetched instruction and its PC
//   i_flush                 redirect: drop queue, output register and this cycle's fetch
//   o_valid/i_ready         downstream (EX) handshake
//   o_pc, o_inst            PC and raw instruction of the registered entry
//   o_rs1, o_rs2, o_rd      register indices, 0 when unused or illegal
//   o_imm                   sign-extended immediate, 0 for R-type
//   o_is_*                  class flags; o_is_jump covers JAL and JALR
//   o_illegal               unsupported opcode (still delivered)
//   o_count                 queue occupancy
module dec_queue_stage #(
    parameter int unsigned DEPTH = 4,
    parameter bit          EN_M  = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_f_valid,
    output logic                     o_f_ready,
    input  logic [31:0]              i_f_inst,
    input  logic [31:0]              i_f_pc,
    input  logic                     i_flush,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [31:0]              o_pc,
    output logic [31:0]              o_inst,
    output logic [4:0]               o_rs1,
    output logic [4:0]               o_rs2,
    output logic [4:0]               o_rd,
    output logic [31:0]              o_imm,
    output logic                     o_is_load,
    output logic                     o_is_store,
    output logic                     o_is_branch,
    output logic                     o_is_jump,
    output logic                     o_is_mul,
    output logic                     o_illegal,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jump;
        logic        is_mul;
        logic        illegal;
    } dec_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    entry_t          head_c;
    dec_t            dec_c;
    dec_t            out_q;
    logic            hazard_c;
    logic            out_free_c;
    logic            push_c;
    logic            pop_c;

    // Handshake qualifiers; flush overrides both push and pop.
    assign o_f_ready  = (count < CW'(DEPTH));
    assign out_free_c = !o_valid || i_ready;
    assign push_c     = i_f_valid && o_f_ready && !i_flush;
    assign pop_c      = (count != '0) && out_free_c && !hazard_c && !i_flush;

    assign head_c = mem[rd_ptr];

    // Decode the queue head; unused register fields stay 0.
    always_comb begin
        logic [31:0] inst;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        logic [31:0] imm_b;
        logic [31:0] imm_u;
        logic [31:0] imm_j;

        dec_c = '0;
        inst  = head_c.inst;
        imm_i = {{20{inst[31]}}, inst[31:20]};
        imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        imm_u = {inst[31:12], 12'b0};
        imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

        case (inst[6:0])
            OPC_LUI, OPC_AUIPC: begin
                dec_c.rd  = inst[11:7];
                dec_c.imm = imm_u;
            end
            OPC_JAL: begin
                dec_c.rd      = inst[11:7];
                dec_c.imm     = imm_j;
                dec_c.is_jump = 1'b1;
            end
            OPC_JALR: begin
                dec_c.rs1     = inst[19:15];
                dec_c.rd      = inst[11:7];
                dec_c.imm     = imm_i;
                dec_c.is_jump = 1'b1;
            end
            OPC_BRANCH: begin
                dec_c.rs1       = inst[19:15];
                dec_c.rs2       = inst[24:20];
                dec_c.imm       = imm_b;
                dec_c.is_branch = 1'b1;
            end
            OPC_LOAD: begin
                dec_c.rs1     = inst[19:15];
                dec_c.rd      = inst[11:7];
                dec_c.imm     = imm_i;
                dec_c.is_load = 1'b1;
            end
            OPC_STORE: begin
                dec_c.rs1      = inst[19:15];
                dec_c.rs2      = inst[24:20];
                dec_c.imm      = imm_s;
                dec_c.is_store = 1'b1;
            end
            OPC_OPIMM: begin
                dec_c.rs1 = inst[19:15];
                dec_c.rd  = inst[11:7];
                dec_c.imm = imm_i;
            end
            OPC_OP: begin
                if ((inst[31:25] == F7_MULDIV) && !EN_M) begin
                    dec_c.illegal = 1'b1;
                end else begin
                    dec_c.rs1    = inst[19:15];
                    dec_c.rs2    = inst[24:20];
                    dec_c.rd     = inst[11:7];
                    dec_c.is_mul = (inst[31:25] == F7_MULDIV);
                end
            end
            default: begin
                dec_c.illegal = 1'b1;
            end
        endcase
    end

    // Load-use: head reads the register the registered load writes. Unused
    // and illegal sources decode to 0, and o_rd != 0 keeps x0 out.
    assign hazard_c = o_valid && o_is_load && (o_rd != 5'd0) &&
                      ((dec_c.rs1 == o_rd) || (dec_c.rs2 == o_rd));

    // Queue storage; no reset needed, entries are only read once written.
    always_ff @(posedge i_clk) begin
        if (push_c) begin
            mem[wr_ptr] <= '{pc: i_f_pc, inst: i_f_inst};
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ID/EX output register: load on pop, bubble when free and idle, else hold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_pc    <= '0;
            o_inst  <= '0;
            out_q   <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (pop_c) begin
            o_valid <= 1'b1;
            o_pc    <= head_c.pc;
            o_inst  <= head_c.inst;
            out_q   <= dec_c;
        end else if (out_free_c) begin
            o_valid <= 1'b0;
        end
    end

    assign o_rs1       = out_q.rs1;
    assign o_rs2       = out_q.rs2;
    assign o_rd        = out_q.rd;
    assign o_imm       = out_q.imm;
    assign o_is_load   = out_q.is_load;
    assign o_is_store  = out_q.is_store;
    assign o_is_branch = out_q.is_branch;
    assign o_is_jump   = out_q.is_jump;
    assign o_is_mul    = out_q.is_mul;
    assign o_illegal   = out_q.illegal;
    assign o_count     = count;

endmodule

// File: tb/tb_dec_queue_stage.sv
module tb_dec_queue_stage;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_f_valid;
    logic [31:0] i_f_inst;
    logic [31:0] i_f_pc;
    logic        i_flush;
    logic        i_ready;

    // EN_M = 1 instance
    logic        o_f_ready, o_valid, o_is_load, o_is_store, o_is_branch, o_is_jump, o_is_mul, o_illegal;
    logic [31:0] o_pc, o_inst, o_imm;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic [2:0]  o_count;

    // EN_M = 0 instance, same stimulus
    logic        m0_f_ready, m0_valid, m0_is_load, m0_is_store, m0_is_branch, m0_is_jump, m0_is_mul, m0_illegal;
    logic [31:0] m0_pc, m0_inst, m0_imm;
    logic [4:0]  m0_rs1, m0_rs2, m0_rd;
    logic [2:0]  m0_count;

    always #5 i_clk = ~i_clk;

    dec_queue_stage #(.DEPTH(4), .EN_M(1'b1)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_f_valid(i_f_valid), .o_f_ready(o_f_ready),
        .i_f_inst(i_f_inst), .i_f_pc(i_f_pc), .i_flush(i_flush), .o_valid(o_valid),
        .i_ready(i_ready), .o_pc(o_pc), .o_inst(o_inst), .o_rs1(o_rs1), .o_rs2(o_rs2),
        .o_rd(o_rd), .o_imm(o_imm), .o_is_load(o_is_load), .o_is_store(o_is_store),
        .o_is_branch(o_is_branch), .o_is_jump(o_is_jump), .o_is_mul(o_is_mul),
        .o_illegal(o_illegal), .o_count(o_count)
    );

    dec_queue_stage #(.DEPTH(4), .EN_M(1'b0)) u_dut_m0 (
        .i_clk(i_clk), .i_rst(i_rst), .i_f_valid(i_f_valid), .o_f_ready(m0_f_ready),
        .i_f_inst(i_f_inst), .i_f_pc(i_f_pc), .i_flush(i_flush), .o_valid(m0_valid),
        .i_ready(i_ready), .o_pc(m0_pc), .o_inst(m0_inst), .o_rs1(m0_rs1), .o_rs2(m0_rs2),
        .o_rd(m0_rd), .o_imm(m0_imm), .o_is_load(m0_is_load), .o_is_store(m0_is_store),
        .o_is_branch(m0_is_branch), .o_is_jump(m0_is_jump), .o_is_mul(m0_is_mul),
        .o_illegal(m0_illegal), .o_count(m0_count)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [5:0]  flags;   // {load, store, branch, jump, mul, illegal}
    } exp_t;

    exp_t sb[$];
    exp_t sb0[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] inst,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] imm,
                                input logic [5:0] flags);
        exp_t e;
        e.pc = pc; e.inst = inst; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm; e.flags = flags;
        return e;
    endfunction

    // Monitors: compare whenever an output is consumed.
    always @(negedge i_clk) begin
        if (!i_rst && !i_flush && o_valid === 1'b1 && i_ready) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL m1_unexpected actual_pc=0x%08h expected=none", o_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("m1_pc", o_pc, e.pc);
                chk("m1_inst", o_inst, e.inst);
                chk("m1_rs1", 32'(o_rs1), 32'(e.rs1));
                chk("m1_rs2", 32'(o_rs2), 32'(e.rs2));
                chk("m1_rd", 32'(o_rd), 32'(e.rd));
                if (!e.flags[0]) chk("m1_imm", o_imm, e.imm);
                chk("m1_flags", 32'({o_is_load, o_is_store, o_is_branch, o_is_jump, o_is_mul, o_illegal}),
                    32'(e.flags));
            end
        end
    end

    always @(negedge i_clk) begin
        if (!i_rst && !i_flush && m0_valid === 1'b1 && i_ready) begin
            if (sb0.size() == 0) begin
                checks++; failures++;
                $display("FAIL m0_unexpected actual_pc=0x%08h expected=none", m0_pc);
            end else begin
                exp_t e;
                e = sb0.pop_front();
                chk("m0_pc", m0_pc, e.pc);
                chk("m0_rs1", 32'(m0_rs1), 32'(e.rs1));
                chk("m0_rs2", 32'(m0_rs2), 32'(e.rs2));
                chk("m0_rd", 32'(m0_rd), 32'(e.rd));
                if (!e.flags[0]) chk("m0_imm", m0_imm, e.imm);
                chk("m0_flags", 32'({m0_is_load, m0_is_store, m0_is_branch, m0_is_jump, m0_is_mul, m0_illegal}),
                    32'(e.flags));
            end
        end
    end

    // Offer one instruction (called just after a rising edge); returns just after the accepting edge.
    task automatic push2(input exp_t e1, input exp_t e0);
        int n = 0;
        i_f_valid = 1'b1; i_f_inst = e1.inst; i_f_pc = e1.pc;
        while (!o_f_ready && n < 100) begin
            @(posedge i_clk); #1; n++;
        end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL push_timeout actual=blocked expected=accepted");
        end
        sb.push_back(e1);
        sb0.push_back(e0);
        @(posedge i_clk); #1;
        i_f_valid = 1'b0;
    endtask

    task automatic push(input exp_t e);
        push2(e, e);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge i_clk); #1; end
    endtask

    task automatic drain();
        int n = 0;
        i_ready = 1'b1;
        while ((sb.size() != 0 || o_valid) && n < 200) begin
            @(posedge i_clk); #1; n++;
        end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL drain_timeout actual=%0d expected=0", sb.size());
        end
        cyc(2);
    endtask

    initial begin
        i_rst = 1'b1; i_f_valid = 1'b0; i_f_inst = '0; i_f_pc = '0; i_flush = 1'b0; i_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;

        // Reset state
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_f_ready", 32'(o_f_ready), 32'd1);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_imm", o_imm, 32'd0);
        chk("rst_rd", 32'(o_rd), 32'd0);
        chk("rst_m0_valid", 32'(m0_valid), 32'd0);

        // Streaming: latency 1, one per cycle
        i_ready = 1'b1;
        push(mk(32'h100, 32'h00500093, 5'd0, 5'd0, 5'd1, 32'd5, 6'b000000));
        cyc(1);
        chk("lat_valid", 32'(o_valid), 32'd1);
        chk("lat_pc", o_pc, 32'h100);
        chk("lat_rd", 32'(o_rd), 32'd1);
        chk("lat_imm", o_imm, 32'd5);
        push(mk(32'h104, 32'h00700113, 5'd0, 5'd0, 5'd2, 32'd7, 6'b000000));
        push(mk(32'h108, 32'hFFF08193, 5'd1, 5'd0, 5'd3, 32'hFFFFFFFF, 6'b000000));
        push(mk(32'h10C, 32'h12345237, 5'd0, 5'd0, 5'd4, 32'h12345000, 6'b000000));
        chk("tput_valid0", 32'(o_valid), 32'd1);
        chk("tput_pc0", o_pc, 32'h108);
        cyc(1);
        chk("tput_valid1", 32'(o_valid), 32'd1);
        chk("tput_pc1", o_pc, 32'h10C);
        drain();

        // Backpressure: fill queue, then full-with-pop must not push
        i_ready = 1'b0;
        push(mk(32'h200, 32'h00100293, 5'd0, 5'd0, 5'd5, 32'd1, 6'b000000));
        push(mk(32'h204, 32'h00200313, 5'd0, 5'd0, 5'd6, 32'd2, 6'b000000));
        push(mk(32'h208, 32'h00300393, 5'd0, 5'd0, 5'd7, 32'd3, 6'b000000));
        push(mk(32'h20C, 32'h00400413, 5'd0, 5'd0, 5'd8, 32'd4, 6'b000000));
        push(mk(32'h210, 32'h00500493, 5'd0, 5'd0, 5'd9, 32'd5, 6'b000000));
        chk("full_count", 32'(o_count), 32'd4);
        chk("full_f_ready", 32'(o_f_ready), 32'd0);
        chk("full_valid", 32'(o_valid), 32'd1);
        chk("full_pc", o_pc, 32'h200);
        i_f_valid = 1'b1; i_f_inst = 32'h00600513; i_f_pc = 32'hDEAD0000;
        cyc(2);
        chk("full_hold_count", 32'(o_count), 32'd4);
        chk("full_hold_pc", o_pc, 32'h200);
        i_ready = 1'b1;
        cyc(1);
        i_f_valid = 1'b0;
        chk("full_pop_count", 32'(o_count), 32'd3);
        chk("full_pop_pc", o_pc, 32'h204);
        drain();

        // Load-use: exactly one bubble
        push(mk(32'h300, 32'h00012283, 5'd2, 5'd0, 5'd5, 32'd0, 6'b100000));
        push(mk(32'h304, 32'h00128333, 5'd5, 5'd1, 5'd6, 32'd0, 6'b000000));
        chk("lu_valid_load", 32'(o_valid), 32'd1);
        chk("lu_pc_load", o_pc, 32'h300);
        cyc(1);
        chk("lu_bubble", 32'(o_valid), 32'd0);
        cyc(1);
        chk("lu_valid_use", 32'(o_valid), 32'd1);
        chk("lu_pc_use", o_pc, 32'h304);
        drain();

        // Load to x0: no bubble
        push(mk(32'h320, 32'h00012003, 5'd2, 5'd0, 5'd0, 32'd0, 6'b100000));
        push(mk(32'h324, 32'h00100333, 5'd0, 5'd1, 5'd6, 32'd0, 6'b000000));
        cyc(1);
        chk("x0_no_bubble", 32'(o_valid), 32'd1);
        chk("x0_pc_use", o_pc, 32'h324);
        drain();

        // Immediate formats and classes
        push(mk(32'h400, 32'hFE000EE3, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 6'b001000));
        push(mk(32'h404, 32'h001000EF, 5'd0, 5'd0, 5'd1, 32'h00000800, 6'b000100));
        push(mk(32'h408, 32'h00312423, 5'd2, 5'd3, 5'd0, 32'd8, 6'b010000));
        push(mk(32'h40C, 32'h004100E7, 5'd2, 5'd0, 5'd1, 32'd4, 6'b000100));
        push(mk(32'h410, 32'h00001397, 5'd0, 5'd0, 5'd7, 32'h00001000, 6'b000000));
        drain();

        // MUL with and without M; illegal opcode
        push2(mk(32'h500, 32'h022081B3, 5'd1, 5'd2, 5'd3, 32'd0, 6'b000010),
              mk(32'h500, 32'h022081B3, 5'd0, 5'd0, 5'd0, 32'd0, 6'b000001));
        push(mk(32'h504, 32'h0000007F, 5'd0, 5'd0, 5'd0, 32'd0, 6'b000001));
        drain();

        // Flush with a coincident fetch
        i_ready = 1'b0;
        push(mk(32'h600, 32'h00100093, 5'd0, 5'd0, 5'd1, 32'd1, 6'b000000));
        push(mk(32'h604, 32'h00200093, 5'd0, 5'd0, 5'd1, 32'd2, 6'b000000));
        push(mk(32'h608, 32'h00300093, 5'd0, 5'd0, 5'd1, 32'd3, 6'b000000));
        push(mk(32'h60C, 32'h00400093, 5'd0, 5'd0, 5'd1, 32'd4, 6'b000000));
        chk("pre_flush_count", 32'(o_count), 32'd3);
        chk("pre_flush_valid", 32'(o_valid), 32'd1);
        i_flush = 1'b1; i_ready = 1'b1;
        i_f_valid = 1'b1; i_f_inst = 32'h00900093; i_f_pc = 32'hBAD00000;
        cyc(1);
        i_flush = 1'b0; i_f_valid = 1'b0;
        sb.delete(); sb0.delete();
        chk("flush_count", 32'(o_count), 32'd0);
        chk("flush_valid", 32'(o_valid), 32'd0);
        chk("flush_f_ready", 32'(o_f_ready), 32'd1);
        cyc(2);
        chk("flush_stays_empty", 32'(o_valid), 32'd0);
        push(mk(32'h700, 32'h00A00093, 5'd0, 5'd0, 5'd1, 32'd10, 6'b000000));
        drain();

        // Reset while a load-use stall is in progress
        push(mk(32'h800, 32'h00012283, 5'd2, 5'd0, 5'd5, 32'd0, 6'b100000));
        i_ready = 1'b0;
        push(mk(32'h804, 32'h00128333, 5'd5, 5'd1, 5'd6, 32'd0, 6'b000000));
        i_rst = 1'b1;
        cyc(1);
        i_rst = 1'b0;
        sb.delete(); sb0.delete();
        chk("rst2_valid", 32'(o_valid), 32'd0);
        chk("rst2_count", 32'(o_count), 32'd0);
        chk("rst2_pc", o_pc, 32'd0);
        chk("rst2_is_load", 32'(o_is_load), 32'd0);
        i_ready = 1'b1;
        push(mk(32'h900, 32'h00128333, 5'd5, 5'd1, 5'd6, 32'd0, 6'b000000));
        cyc(1);
        chk("rst2_no_stall", 32'(o_valid), 32'd1);
        drain();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("sb0_empty", 32'(sb0.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
